prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial receive-side checker for the team's Fibonacci LFSR pattern generator.
- Accepts one bit per valid cycle, self-synchronises to the incoming pseudo-random sequence, declares lock, then counts bit errors against a free-running local replica.
- Sits at the far end of a link or loopback path driven by the LFSR generator and provides link-quality status to test logic.

Parameters:
- WIDTH, 3: LFSR length in bits.
- TAPS, 3'b101: feedback mask. Predicted next bit = XOR-reduce(sr & TAPS).
- LOCK_CNT, 4: consecutive correct predictions required to declare lock.
- LOSS_CNT, 4: errors within one window that force loss of lock.
- WINDOW, 16: window length in valid bits while locked.
- CNT_W, 8: width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- din  input  1  received serial bit.
- din_valid  input  1  din is sampled only when high.
- clr_cnt  input  1  synchronous clear of err_count.
- locked  output  1  high while in state LOCK.
- err_pulse  output  1  one-cycle pulse for each mismatch detected in LOCK.
- err_count  output  CNT_W  saturating count of mismatches detected in LOCK.
- sync_state  output  2  current state: 0=HUNT, 1=SYNC, 2=LOCK.

Behaviour:
- Stream convention: the generator shifts left, inserting new bit = q[2]^q[0] at the LSB; that inserted bit is the transmitted bit. Reset seed 100 gives the period-7 stream 1,1,1,0,1,0,0, repeating.
- Shift register sr[WIDTH-1:0]: sr[0] is the newest bit. pred = ^(sr & TAPS).
- Reset, and reset asserted at any time including mid-operation: state=HUNT; sr, fill count, match count, window count, error-in-window count, err_count all 0; locked=0, err_pulse=0, sync_state=0. Reset takes effect on the next clk edge.
- din_valid=0: no state or register change; err_pulse=0.
- HUNT: each valid bit does sr <= {sr[WIDTH-2:0], din} and increments the fill count. After the WIDTH-th valid bit, go to SYNC with match count 0. No comparison is made in HUNT.
- SYNC: each valid bit does sr <= {sr, din}, i.e. the register self-loads from din.
  - A match is din==pred AND sr!=0. A match increments the match count; the LOCK_CNT-th consecutive match moves the block to LOCK.
  - Any non-match resets the match count to 0 and the block stays in SYNC.
  - Because an all-zero sr never counts as a match, a stuck-at-0 input never locks.
- LOCK: each valid bit does sr <= {sr, pred}. The local generator free-runs, so one flipped input bit produces exactly one error, with no multiplication.
  - On din!=pred: err_pulse=1 in the next cycle, err_count increments and saturates at 2^CNT_W-1, and the error-in-window count increments.
  - Window count runs over 0..WINDOW-1 on valid bits. After the last bit of a window is processed, the error-in-window count clears.
  - If a mismatch brings the error-in-window count to LOSS_CNT: go to HUNT, clear the fill count, and drop locked on the next cycle. That mismatch is still counted and pulsed.
  - On entry to LOCK, window count and error-in-window count are 0.
- clr_cnt=1: err_count becomes 0, with priority over a simultaneous increment. err_pulse is unaffected. Lock state is unaffected.
- Latency: all outputs are registered.
  - locked rises the cycle after the valid bit that completes LOCK_CNT matches.
  - For a clean stream, lock occurs after WIDTH+LOCK_CNT = 7 valid bits.

Test Plan:
- Reset, then clean stream 1,1,1,0,1,0,0 repeating with din_valid=1 every cycle -> locked=1 and sync_state=2 one cycle after the 7th bit; err_count=0 and no err_pulse over 70 bits.
- After lock, invert exactly one bit -> exactly one err_pulse, one cycle after that bit; err_count=1; locked stays 1.
- din held at 0 for 50 valid bits -> sync_state cycles HUNT then stays SYNC; locked never rises; err_count=0.
- After lock, switch to the bitwise-inverted stream -> 4 consecutive err_pulses; err_count=4; locked=0 after the 4th; block then stays in SYNC and never relocks on the inverted stream.
- CNT_W=2, after lock inject 5 isolated errors, each in a separate window -> err_count saturates at 3. Then assert clr_cnt in the same cycle as a new error -> err_count=0 and err_pulse=1.
- din_valid toggling every other cycle on the clean stream -> lock after 7 valid bits (about 14 cycles); then assert rst for 1 cycle mid-lock -> locked=0, sync_state=0, err_count=0 on the next edge, and relock after 7 further valid bits.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker: serial receive-side checker for the Fibonacci LFSR pattern
// generator. Hunts for the incoming pseudo-random stream, confirms it with
// LOCK_CNT consecutive correct predictions, then free-runs a local replica
// and counts bit errors. Too many errors inside one window drop lock.
module prbs_checker #(
  parameter int               WIDTH    = 3,
  parameter logic [WIDTH-1:0] TAPS     = 3'b101,
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 4,
  parameter int               WINDOW   = 16,
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       sync_state
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EWIN_W  = $clog2(LOSS_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [EWIN_W-1:0]  ewin_q, ewin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               locked_q;

  // Prediction of the next stream bit from the last WIDTH bits.
  logic              pred;
  logic              mismatch;
  logic              sr_nonzero;
  logic [EWIN_W-1:0] ewin_inc;

  assign pred       = ^(sr_q & TAPS);
  assign mismatch   = (din != pred);
  assign sr_nonzero = (sr_q != '0);
  assign ewin_inc   = ewin_q + 1'b1;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      sr_q     <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      win_q    <= '0;
      ewin_q   <= '0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block, regardless of
      // statement order.
      state_q  <= state_d;
      sr_q     <= sr_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      win_q    <= win_d;
      ewin_q   <= ewin_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      locked_q <= (state_d == LOCK);
    end
  end

  // Next-state logic: hunt/sync/lock sequencing, error counting, windowing.
  always_comb begin
    // NOTE: every variable gets a hold/default value first so that no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d = state_q;
    sr_d    = sr_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    ewin_d  = ewin_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          // Fill the shift register without judging anything.
          sr_d   = {sr_q[WIDTH-2:0], din};
          fill_d = fill_q + 1'b1;
          if (fill_q == FILL_W'(WIDTH - 1)) begin
            state_d = SYNC;
            match_d = '0;
          end
        end

        SYNC: begin
          // Self-load from the line; an all-zero register never counts as a
          // match so a stuck-at-0 input cannot lock.
          sr_d = {sr_q[WIDTH-2:0], din};
          if (!mismatch && sr_nonzero) begin
            match_d = match_q + 1'b1;
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d = LOCK;
              win_d   = '0;
              ewin_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end

        LOCK: begin
          // Free-running replica: a single flipped input bit is one error.
          sr_d = {sr_q[WIDTH-2:0], pred};

          if (win_q == WIN_W'(WINDOW - 1)) begin
            win_d  = '0;
            ewin_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            ewin_d = mismatch ? ewin_inc : ewin_q;
          end

          if (mismatch) begin
            pulse_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (ewin_inc == EWIN_W'(LOSS_CNT)) begin
              state_d = HUNT;
              fill_d  = '0;
            end
          end
        end

        default: begin
          state_d = HUNT;
          fill_d  = '0;
        end
      endcase
    end

    // Clearing the counter wins over a simultaneous increment.
    if (clr_cnt) begin
      cnt_d = '0;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = pulse_q;
  assign err_count  = cnt_q;
  assign sync_state = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: scoreboard bench for prbs_checker. Two instances share the
// stimulus (CNT_W=8 and CNT_W=2) so counter saturation is seen on the narrow
// one. A behavioural model pushes expected outputs; a monitor pops them.
module tb_prbs_checker;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       clr_cnt;

  logic       locked_a, err_pulse_a;
  logic [7:0] err_count_a;
  logic [1:0] sync_state_a;
  logic       locked_b, err_pulse_b;
  logic [1:0] err_count_b;
  logic [1:0] sync_state_b;

  prbs_checker #(.CNT_W(8)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .clr_cnt    (clr_cnt),
    .locked     (locked_a),
    .err_pulse  (err_pulse_a),
    .err_count  (err_count_a),
    .sync_state (sync_state_a)
  );

  prbs_checker #(.CNT_W(2)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .clr_cnt    (clr_cnt),
    .locked     (locked_b),
    .err_pulse  (err_pulse_b),
    .err_count  (err_count_b),
    .sync_state (sync_state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    bit locked;
    int state;
    bit pulse;
    int cnt_a;
    int cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  // ------------------------------------------------------- behavioural model
  // Mode 0=HUNT 1=SYNC 2=LOCK. m_hist[0] is the most recent bit held by the
  // checker's register; in LOCK it holds the locally generated stream.
  bit  tap_mask [0:2] = '{1'b1, 1'b0, 1'b1};  // index i -> TAPS bit i
  bit  pat      [0:6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  int  phase;

  int  m_mode, m_fill, m_match, m_win, m_errwin, m_cnt_a, m_cnt_b;
  bit  m_pulse;
  bit  m_hist[$];

  task automatic model_reset();
    m_mode   = 0;
    m_fill   = 0;
    m_match  = 0;
    m_win    = 0;
    m_errwin = 0;
    m_cnt_a  = 0;
    m_cnt_b  = 0;
    m_pulse  = 1'b0;
    m_hist   = '{1'b0, 1'b0, 1'b0};
  endtask

  task automatic model_push(input bit b);
    m_hist.push_front(b);
    void'(m_hist.pop_back());
  endtask

  task automatic model_step(input bit r, input bit v, input bit d, input bit c);
    bit p;
    bit nz;
    bit lost;
    if (r) begin
      model_reset();
      return;
    end
    m_pulse = 1'b0;
    if (v) begin
      p  = 1'b0;
      nz = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (tap_mask[i]) p = p ^ m_hist[i];
        if (m_hist[i]) nz = 1'b1;
      end
      case (m_mode)
        0: begin
          model_push(d);
          m_fill++;
          if (m_fill == 3) begin
            m_mode  = 1;
            m_match = 0;
          end
        end
        1: begin
          if (d == p && nz) begin
            m_match++;
            if (m_match == 4) begin
              m_mode   = 2;
              m_win    = 0;
              m_errwin = 0;
            end
          end else begin
            m_match = 0;
          end
          model_push(d);
        end
        default: begin
          lost = 1'b0;
          if (d != p) begin
            m_pulse = 1'b1;
            m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
            m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
            m_errwin++;
            lost = (m_errwin == 4);
          end
          m_win++;
          if (m_win == 16) begin
            m_win    = 0;
            m_errwin = 0;
          end
          if (lost) begin
            m_mode = 0;
            m_fill = 0;
          end
          model_push(p);
        end
      endcase
    end
    if (c) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end
  endtask

  // ------------------------------------------------------------------ driver
  task automatic drive(input bit r, input bit v, input bit d, input bit c);
    exp_t e;
    @(negedge clk);
    rst       = r;
    din_valid = v;
    din       = d;
    clr_cnt   = c;
    model_step(r, v, d, c);
    e.locked = (m_mode == 2);
    e.state  = m_mode;
    e.pulse  = m_pulse;
    e.cnt_a  = m_cnt_a;
    e.cnt_b  = m_cnt_b;
    exp_q.push_back(e);
  endtask

  task automatic send(input int n, input bit invert);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, pat[phase] ^ invert, 1'b0);
      phase = (phase + 1) % 7;
    end
  endtask

  task automatic send_err(input bit c);
    drive(1'b0, 1'b1, ~pat[phase], c);
    phase = (phase + 1) % 7;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    phase = 0;
  endtask

  // ----------------------------------------------------------------- monitor
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("locked_a",     32'(locked_a),     32'(e.locked));
        check("sync_state_a", 32'(sync_state_a), 32'(e.state));
        check("err_pulse_a",  32'(err_pulse_a),  32'(e.pulse));
        check("err_count_a",  32'(err_count_a),  32'(e.cnt_a));
        check("locked_b",     32'(locked_b),     32'(e.locked));
        check("sync_state_b", 32'(sync_state_b), 32'(e.state));
        check("err_pulse_b",  32'(err_pulse_b),  32'(e.pulse));
        check("err_count_b",  32'(err_count_b),  32'(e.cnt_b));
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin : stimulus
    rst       = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
    phase     = 0;
    model_reset();

    // Reset state, then clean stream: lock after 7 bits, no errors.
    do_reset();
    do_reset();
    send(70, 1'b0);

    // One flipped bit while locked: one pulse, count 1, lock kept.
    send_err(1'b0);
    send(20, 1'b0);

    // Stuck-at-0 input never locks.
    do_reset();
    repeat (50) drive(1'b0, 1'b1, 1'b0, 1'b0);

    // Inverted stream after lock, errors starting at a window boundary.
    do_reset();
    send(23, 1'b0);
    send(30, 1'b1);

    // Isolated errors, one per window: narrow counter saturates at 3.
    do_reset();
    send(7, 1'b0);
    repeat (5) begin
      send(8, 1'b0);
      send_err(1'b0);
      send(7, 1'b0);
    end
    // Clear coinciding with a fresh error: count 0, pulse still 1.
    send_err(1'b1);
    send(10, 1'b0);

    // din_valid every other cycle, reset mid-lock, relock.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) send(1, 1'b0);
      else drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) send(1, 1'b0);
      else drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Randomised traffic: gaps, sparse errors, inverted bursts, clears, resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int  sel;
      bit  v;
      bit  d;
      bit  c;
      sel = int'($urandom_range(0, 999));
      if (sel < 3) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        c = v && ($urandom_range(0, 99) == 0);
        if (v) begin
          d = pat[phase];
          if ($urandom_range(0, 39) == 0) d = ~d;
          if ((i / 200) % 5 == 4 && (i % 200) < 12) d = ~pat[phase];
          phase = (phase + 1) % 7;
        end else begin
          d = 1'($urandom_range(0, 1));
        end
        drive(1'b0, v, d, c);
      end
    end

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
